// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_checker
// Description : Response checker for the alu datapath. Each accepted operand
//               transaction is run through a golden model and the expected P
//               is delayed LATENCY cycles, then compared against dut_p.
//               Pass/fail counts saturate; the first mismatch is captured.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   pulse: clear results and pipeline, enter RUN
//   finish     in   pulse: stop accepting, drain in-flight compares
//   in_valid   in   operand transaction issued to the ALU this cycle
//   in_a/b/d   in   18-bit signed operands
//   in_c       in   48-bit operand C
//   in_cin     in   carry in
//   in_sel     in   opcode
//   dut_p      in   P output of the ALU under check
//   busy       out  high in RUN or DRAIN
//   done       out  high in DONE
//   err        out  sticky first-mismatch flag
//   pass_cnt   out  matching compares (saturating)
//   fail_cnt   out  mismatching compares (saturating)
//   first_exp  out  expected value at first mismatch
//   first_got  out  dut_p value at first mismatch
// ============================================================================
module alu_result_checker #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    input  logic [17:0]      in_a,
    input  logic [17:0]      in_b,
    input  logic [17:0]      in_d,
    input  logic [47:0]      in_c,
    input  logic             in_cin,
    input  logic [1:0]       in_sel,
    input  logic [47:0]      dut_p,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [47:0]      first_exp,
    output logic [47:0]      first_got
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int               c_DCNT_W  = 4;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Golden model
    // ------------------------------------------------------------------
    logic signed [17:0] w_pre;
    logic        [35:0] w_mul_pre;
    logic        [35:0] w_mul_ab;
    logic        [47:0] w_mul_pre_x;
    logic        [47:0] w_mul_ab_x;
    logic        [47:0] w_cin_x;
    logic        [47:0] w_exp;

    always_comb begin
        // Pre-adder wraps at 18 bits; sel[1] selects D-A.
        w_pre       = in_sel[1] ? (in_d - in_a) : (in_d + in_a);
        // Operands are widened to 36 bits so the low 36 bits of the
        // product are the exact signed 18x18 result.
        w_mul_pre   = $signed({{18{w_pre[17]}}, w_pre}) * $signed({{18{in_b[17]}}, in_b});
        w_mul_ab    = $signed({{18{in_a[17]}}, in_a}) * $signed({{18{in_b[17]}}, in_b});
        w_mul_pre_x = {{12{w_mul_pre[35]}}, w_mul_pre};
        w_mul_ab_x  = {{12{w_mul_ab[35]}}, w_mul_ab};
        w_cin_x     = {47'd0, in_cin};
        case (in_sel)
            2'd0, 2'd2: w_exp = in_c + w_mul_pre_x + w_cin_x;
            2'd1:       w_exp = in_c - (w_mul_pre_x + w_cin_x);
            default:    w_exp = w_mul_ab_x + w_cin_x;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    logic [1:0]          state_q, state_d;
    logic [c_DCNT_W-1:0] dcnt_q, dcnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (start) begin
            // start overrides finish and applies from any state
            state_d = S_RUN;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (finish) begin
                        state_d = S_DRAIN;
                        dcnt_d  = c_DCNT_W'(LATENCY);
                    end
                end
                S_DRAIN: begin
                    // Leaving on the edge the counter hits zero coincides with
                    // the last in-flight compare retiring.
                    if (dcnt_q <= c_DCNT_W'(1)) begin
                        state_d = S_DONE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q - c_DCNT_W'(1);
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_DONE);
    end

    // ------------------------------------------------------------------
    // Expected-value pipeline
    // ------------------------------------------------------------------
    logic               w_accept;
    logic [LATENCY-1:0] pv_q, pv_d;
    logic [47:0]        pe_q [LATENCY];
    logic [47:0]        pe_d [LATENCY];

    assign w_accept = in_valid && (start || (state_q == S_RUN));

    always_comb begin
        pv_d    = '0;
        pv_d[0] = w_accept;
        pe_d[0] = w_exp;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = start ? 1'b0 : pv_q[i-1];
            pe_d[i] = pe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
        end else begin
            pv_q <= pv_d;
        end
        pe_q <= pe_d;
    end

    // ------------------------------------------------------------------
    // Compare and result capture
    // ------------------------------------------------------------------
    logic             w_tail_v;
    logic             w_match;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;
    logic [47:0]      fexp_q, fexp_d;
    logic [47:0]      fgot_q, fgot_d;

    assign w_tail_v = pv_q[LATENCY-1];
    assign w_match  = (dut_p == pe_q[LATENCY-1]);

    always_comb begin
        pass_d = pass_q;
        fail_d = fail_q;
        err_d  = err_q;
        fexp_d = fexp_q;
        fgot_d = fgot_q;
        if (start) begin
            pass_d = '0;
            fail_d = '0;
            err_d  = 1'b0;
            fexp_d = '0;
            fgot_d = '0;
        end else if (w_tail_v) begin
            if (w_match) begin
                if (pass_q != c_CNT_MAX) pass_d = pass_q + c_CNT_ONE;
            end else begin
                if (fail_q != c_CNT_MAX) fail_d = fail_q + c_CNT_ONE;
                if (!err_q) begin
                    err_d  = 1'b1;
                    fexp_d = pe_q[LATENCY-1];
                    fgot_d = dut_p;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_q <= '0;
            fail_q <= '0;
            err_q  <= 1'b0;
            fexp_q <= '0;
            fgot_q <= '0;
        end else begin
            pass_q <= pass_d;
            fail_q <= fail_d;
            err_q  <= err_d;
            fexp_q <= fexp_d;
            fgot_q <= fgot_d;
        end
    end

    assign pass_cnt  = pass_q;
    assign fail_cnt  = fail_q;
    assign err       = err_q;
    assign first_exp = fexp_q;
    assign first_got = fgot_q;

endmodule
`default_nettype wire
